// File: rtl/cache_types_pkg.sv
// Shared cache-side constants and the cacheline adaptor state encoding.
package cache_types_pkg;

    localparam int unsigned CACHE_BEAT_W      = 64;
    localparam int unsigned CACHE_BEATS       = 4;
    localparam int unsigned CACHE_LINE_W      = CACHE_BEAT_W * CACHE_BEATS;
    localparam int unsigned CACHE_OFFSET_BITS = 5;
    localparam int unsigned CACHE_ADDR_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges one 256-bit cacheline transfer to a 4 x 64-bit memory burst (fill or write-back).
module cacheline_adaptor
    import cache_types_pkg::*;
#(
    parameter int unsigned BEAT_W = CACHE_BEAT_W,
    parameter int unsigned BEATS  = CACHE_BEATS,
    parameter int unsigned ADDR_W = CACHE_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    // cache side
    input  logic [BEAT_W*BEATS-1:0]   line_i,
    output logic [BEAT_W*BEATS-1:0]   line_o,
    input  logic [ADDR_W-1:0]         address_i,
    input  logic                      read_i,
    input  logic                      write_i,
    output logic                      resp_o,
    // memory side
    input  logic [BEAT_W-1:0]         burst_i,
    output logic [BEAT_W-1:0]         burst_o,
    output logic [ADDR_W-1:0]         address_o,
    output logic                      read_o,
    output logic                      write_o,
    input  logic                      resp_i
);

    localparam int unsigned LINE_W = BEAT_W * BEATS;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned SEL_W  = $clog2(BEAT_W);
    localparam int unsigned OFFSET = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFFSET) - ADDR_W'(1));

    adaptor_state_e           r_state;
    adaptor_state_e           w_state_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [ADDR_W-1:0]        r_addr;
    logic [LINE_W-1:0]        r_line;
    logic [CNT_W+SEL_W-1:0]   w_beat_lsb;
    logic                     w_last_beat;

    // Bit offset of the current beat inside the line (beat 0 is the lowest word).
    assign w_beat_lsb  = {r_cnt, {SEL_W{1'b0}}};
    assign w_last_beat = resp_i && (r_cnt == LAST_BEAT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one transaction at a time, read wins over write.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (read_i) begin
                    w_state_next = READ;
                end else if (write_i) begin
                    w_state_next = WRITE;
                end
            end
            READ, WRITE: begin
                if (w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: address latch, line buffer and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_line <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (read_i) begin
                        r_addr <= address_i & ALIGN_MASK;
                    end else if (write_i) begin
                        r_addr <= address_i & ALIGN_MASK;
                        r_line <= line_i;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_line[w_beat_lsb +: BEAT_W] <= burst_i;
                        r_cnt <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        r_cnt <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        burst_o   = '0;
        address_o = r_addr;
        line_o    = r_line;
        case (r_state)
            READ:  read_o = 1'b1;
            WRITE: begin
                write_o = 1'b1;
                burst_o = r_line[w_beat_lsb +: BEAT_W];
            end
            DONE:    resp_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: driver acts as cache and memory, monitor checks outputs.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int n_pass  = 0;
    int n_total = 0;

    // Scoreboard state shared between driver and monitor.
    logic [255:0] exp_resp_q[$];
    logic [63:0]  exp_wbeat_q[$];
    logic [31:0]  exp_addr;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compares every DUT-presented output against queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_o) begin
                chk("resp_expected", 256'(exp_resp_q.size() != 0), 256'(1));
                if (exp_resp_q.size() != 0) begin
                    chk("line_o", line_o, exp_resp_q.pop_front());
                end
            end
            if (read_o || write_o) begin
                chk("address_o", 256'(address_o), 256'(exp_addr));
                chk("strobe_excl", 256'(read_o && write_o), 256'(0));
            end
            if (write_o && resp_i) begin
                chk("wbeat_expected", 256'(exp_wbeat_q.size() != 0), 256'(1));
                if (exp_wbeat_q.size() != 0) begin
                    chk("burst_o", 256'(burst_o), 256'(exp_wbeat_q.pop_front()));
                end
            end
        end
    end

    // One cache transaction; mode 0 = back-to-back beats, 1 = fixed stall pattern, 2 = random.
    // Entered and left 1 time unit after a rising edge.
    task automatic do_txn(input bit is_read, input bit both, input logic [31:0] addr,
                          input logic [255:0] data, input int mode);
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int beats = 0;
        int pi    = 0;
        int waitc = 0;
        bit take_read;
        bit r;
        take_read = is_read || both;
        exp_addr  = {addr[31:5], 5'b0};
        exp_resp_q.push_back(data);
        if (!take_read) begin
            for (int k = 0; k < 4; k++) exp_wbeat_q.push_back(data[k*64 +: 64]);
        end
        read_i    = take_read;
        write_i   = !take_read || both;
        address_i = addr;
        line_i    = take_read ? rand_line() : data;
        resp_i    = 1'($urandom);
        burst_i   = {$urandom, $urandom};
        @(posedge clk); #1;
        resp_i = 1'b0;
        chk("req_latency", 256'(take_read ? read_o : write_o), 256'(1));
        chk("req_other_low", 256'(take_read ? write_o : read_o), 256'(0));
        while (beats < 4 && waitc < 64) begin
            chk("strobe_held", 256'(take_read ? read_o : write_o), 256'(1));
            chk("resp_low_in_burst", 256'(resp_o), 256'(0));
            if (mode == 0) r = 1'b1;
            else if (mode == 1) r = (pi < 7) ? (pat[pi] != 0) : 1'b1;
            else r = ($urandom_range(2) != 0);
            pi++;
            resp_i  = r;
            burst_i = r ? data[beats*64 +: 64] : {$urandom, $urandom};
            @(posedge clk); #1;
            if (r) beats++;
            waitc++;
        end
        resp_i = 1'b0;
        chk("burst_in_budget", 256'(beats), 256'(4));
        chk("resp_latency", 256'(resp_o), 256'(1));
        chk("strobe_drop", 256'(read_o || write_o), 256'(0));
        read_i  = 1'b0;
        write_i = 1'b0;
        @(posedge clk); #1;
        chk("resp_single", 256'(resp_o), 256'(0));
    endtask

    initial begin
        logic [255:0] d;
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_o", 256'(read_o), 256'(0));
        chk("rst_write_o", 256'(write_o), 256'(0));
        chk("rst_resp_o", 256'(resp_o), 256'(0));
        chk("rst_line_o", line_o, 256'(0));
        chk("rst_burst_o", 256'(burst_o), 256'(0));
        chk("rst_address_o", 256'(address_o), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed read fill with consecutive beats.
        d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_txn(1'b1, 1'b0, 32'h0000_1234, d, 0);
        chk("fill_addr", 256'(address_o), 256'(32'h0000_1220));

        // Directed write-back of {D,C,B,A}.
        d = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        do_txn(1'b0, 1'b0, 32'h0000_8040, d, 0);

        // Stalled read burst.
        do_txn(1'b1, 1'b0, 32'hCAFE_F00D, rand_line(), 1);

        // Simultaneous read and write request: read wins.
        do_txn(1'b1, 1'b1, 32'h1357_9BDF, rand_line(), 2);

        // Reset after beat 2 of a write.
        d = rand_line();
        exp_addr = 32'h0000_4000;
        for (int k = 0; k < 4; k++) exp_wbeat_q.push_back(d[k*64 +: 64]);
        write_i   = 1'b1;
        address_i = 32'h0000_4010;
        line_i    = d;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk("abort_write_o", 256'(write_o), 256'(1));
            resp_i = 1'b1;
            @(posedge clk); #1;
        end
        resp_i  = 1'b0;
        write_i = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_wbeat_q.delete();
        chk("abort_write_low", 256'(write_o), 256'(0));
        chk("abort_no_resp", 256'(resp_o), 256'(0));
        chk("abort_read_low", 256'(read_o), 256'(0));
        chk("abort_line_clr", line_o, 256'(0));

        // resp_i pulsing while idle must be ignored.
        for (int k = 0; k < 6; k++) begin
            resp_i  = 1'($urandom);
            burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("idle_quiet", 256'({read_o, write_o, resp_o}), 256'(0));
        end
        resp_i = 1'b0;

        // Read after the abort must start from beat 0.
        do_txn(1'b1, 1'b0, 32'h0000_4020, rand_line(), 0);

        // Randomized mix.
        for (int t = 0; t < 40; t++) begin
            do_txn(1'($urandom), ($urandom_range(3) == 0), $urandom, rand_line(), 2);
            repeat ($urandom_range(2)) begin
                resp_i = 1'($urandom);
                @(posedge clk); #1;
            end
            resp_i = 1'b0;
        end

        @(posedge clk); #1;
        chk("resp_q_drained", 256'(exp_resp_q.size()), 256'(0));
        chk("wbeat_q_drained", 256'(exp_wbeat_q.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
